// File: rtl/spram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B: round-robin arbitration with bounded lock bursts.
// Latency: grant and RAM drive are combinational in the request cycle; read data is valid one cycle later.
// Backpressure: the request is held off by a deasserted x_gnt; read responses cannot be stalled.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   x_req/x_we/x_addr/x_wdata     per-requester beat (x = a, b): read or write
//   x_lock                        keep ownership after this beat (bounded by MAX_HOLD)
//   x_gnt                         beat accepted this cycle
//   x_rvalid                      rdata carries x's read result this cycle
//   rdata                         shared read data (pass-through of ram_out)
//   ram_we/ram_addr/ram_data      RAM drive, zero when nobody is granted
//   ram_out                       registered RAM output, valid one cycle after addr
module spram_port_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_b;      // 1: B won the most recent beat
    logic [HW-1:0] hold_cnt;    // beats granted to the current locked owner
    logic [HW-1:0] hold_nxt;
    logic [HW-1:0] hold_inc;
    logic          rr_a;
    logic          rr_b;
    logic          sel_a;
    logic          sel_b;

    // Plain round-robin pick, used when nobody owns the port (or the owner
    // went quiet, which releases it without a dead cycle).
    assign rr_a = a_req && (!b_req || last_b);
    assign rr_b = b_req && !rr_a;

    assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (state)
            OWN_A: begin
                if (a_req) begin
                    // Owner keeps the port until its budget is spent, and
                    // beyond that only while the other side stays idle.
                    if (hold_cnt < HOLD_MAX || !b_req) sel_a = 1'b1;
                    else                               sel_b = 1'b1;
                end else begin
                    sel_b = b_req;
                end
            end
            OWN_B: begin
                if (b_req) begin
                    if (hold_cnt < HOLD_MAX || !a_req) sel_b = 1'b1;
                    else                               sel_a = 1'b1;
                end else begin
                    sel_a = a_req;
                end
            end
            default: begin
                sel_a = rr_a;
                sel_b = rr_b;
            end
        endcase
    end

    // Ownership follows the lock bit of whichever beat was accepted; a
    // beat without lock (or no beat at all) always returns to IDLE.
    always_comb begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        if (sel_a && a_lock) begin
            state_nxt = OWN_A;
            hold_nxt  = (state == OWN_A) ? hold_inc : HOLD_ONE;
        end else if (sel_b && b_lock) begin
            state_nxt = OWN_B;
            hold_nxt  = (state == OWN_B) ? hold_inc : HOLD_ONE;
        end
    end

    // Grants are suppressed while reset is held so the RAM sees no beat.
    assign a_gnt = sel_a & rst_n;
    assign b_gnt = sel_b & rst_n;

    assign ram_we   = (a_gnt & a_we) | (b_gnt & b_we);
    assign ram_addr = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
    assign ram_data = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);
    assign rdata    = ram_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            hold_cnt <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (a_gnt)      last_b <= 1'b0;
            else if (b_gnt) last_b <= 1'b1;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
        end
    end

endmodule
